// File: rtl/oled_arb_pkg.sv
// rtl/oled_arb_pkg.sv - shared widths and FSM states for the OLED write arbiter
package oled_arb_pkg;

   localparam int ADDR_W = 9;
   localparam int CHAR_W = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      W_LOW  = 3'd1,
      W_HIGH = 3'd2,
      U_LOW  = 3'd3,
      U_HIGH = 3'd4
   } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first request at or above ptr, wrapping
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx
);

   // walk from the farthest offset back to ptr so the closest request is written last and wins
   always_comb begin
      int sel;
      grant = '0;
      idx   = '0;
      sel   = 0;
      for (int off = N - 1; off >= 0; off--) begin
         sel = (int'(ptr) + off) % N;
         if (req[sel]) begin
            grant      = '0;
            grant[sel] = 1'b1;
            idx        = IDX_W'(sel);
         end
      end
   end

endmodule

// File: rtl/oled_write_arbiter.sv
// rtl/oled_write_arbiter.sv - shares OLED_ctrl write/update ports among N requesters
module oled_write_arbiter
   import oled_arb_pkg::*;
#(
   parameter int N_REQ         = 4,
   parameter int UPDATE_PERIOD = 1_000_000,
   parameter int CNT_W         = 20
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic [N_REQ-1:0]          req,
   input  logic [CHAR_W*N_REQ-1:0]   req_ascii,
   input  logic [ADDR_W*N_REQ-1:0]   req_addr,
   input  logic                      force_update,
   output logic [N_REQ-1:0]          gnt,
   output logic [N_REQ-1:0]          done,
   output logic                      write_start,
   output logic [CHAR_W-1:0]         write_ascii_data,
   output logic [ADDR_W-1:0]         write_base_addr,
   input  logic                      write_ready,
   output logic                      update_start,
   input  logic                      update_ready,
   output logic                      busy
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam logic [CNT_W-1:0] PERIOD = CNT_W'(UPDATE_PERIOD);

   arb_state_t       state;
   arb_state_t       state_nxt;
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] ptr_nxt;
   logic [N_REQ-1:0] cur;
   logic             dirty;
   logic             force_pend;
   logic [CNT_W-1:0] period_cnt;
   logic             upd_ok;
   logic [N_REQ-1:0] win_grant;
   logic [IDX_W-1:0] win_idx;
   logic [CHAR_W-1:0] sel_ascii;
   logic [ADDR_W-1:0] sel_addr;
   logic             issue_write;
   logic             issue_update;
   logic             write_done;

   rr_arbiter #(
      .N     (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr (
      .req   (req),
      .ptr   (rr_ptr),
      .grant (win_grant),
      .idx   (win_idx)
   );

   assign upd_ok  = (period_cnt >= PERIOD);
   assign ptr_nxt = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
   assign busy    = (state != IDLE);

   // route the winner's character and address toward the output registers
   always_comb begin
      sel_ascii = '0;
      sel_addr  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (win_grant[i]) begin
            sel_ascii = req_ascii[i*CHAR_W +: CHAR_W];
            sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
         end
      end
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next state and one-cycle issue/complete strobes; updates beat writes when both are eligible
   always_comb begin
      state_nxt    = state;
      issue_write  = 1'b0;
      issue_update = 1'b0;
      write_done   = 1'b0;
      case (state)
         IDLE: begin
            if (en && (dirty || force_pend) && upd_ok && update_ready) begin
               issue_update = 1'b1;
               state_nxt    = U_LOW;
            end else if (en && (|req) && write_ready) begin
               issue_write = 1'b1;
               state_nxt   = W_LOW;
            end
         end
         W_LOW:   if (!write_ready) state_nxt = W_HIGH;
         W_HIGH: begin
            if (write_ready) begin
               write_done = 1'b1;
               state_nxt  = IDLE;
            end
         end
         U_LOW:   if (!update_ready) state_nxt = U_HIGH;
         U_HIGH:  if (update_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // registered command outputs, job owner and round-robin pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         write_start      <= 1'b0;
         update_start     <= 1'b0;
         gnt              <= '0;
         done             <= '0;
         write_ascii_data <= '0;
         write_base_addr  <= '0;
         cur              <= '0;
         rr_ptr           <= '0;
      end else begin
         write_start  <= issue_write;
         update_start <= issue_update;
         gnt          <= issue_write ? win_grant : '0;
         done         <= write_done ? cur : '0;
         if (issue_write) begin
            write_ascii_data <= sel_ascii;
            write_base_addr  <= sel_addr;
            cur              <= win_grant;
            rr_ptr           <= ptr_nxt;
         end
      end
   end

   // dirty/force flags and the saturating update-period counter (starts expired)
   always_ff @(posedge clk) begin
      if (rst) begin
         dirty      <= 1'b0;
         force_pend <= 1'b0;
         period_cnt <= PERIOD;
      end else begin
         if (write_done)        dirty <= 1'b1;
         else if (issue_update) dirty <= 1'b0;

         if (force_update)      force_pend <= 1'b1;
         else if (issue_update) force_pend <= 1'b0;

         if (issue_update)      period_cnt <= '0;
         else if (!upd_ok)      period_cnt <= period_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_oled_write_arbiter.sv
// tb/tb_oled_write_arbiter.sv - randomized bench for oled_write_arbiter against a job-level model
`timescale 1ns/1ps
module tb_oled_write_arbiter;

   localparam int N = 4;
   localparam int P = 50;

   logic           clk = 1'b0;
   logic           rst;
   logic           en;
   logic           force_update;
   logic           write_ready;
   logic           update_ready;
   logic [N-1:0]   req;
   logic [N-1:0]   gnt;
   logic [N-1:0]   done;
   logic [8*N-1:0] req_ascii;
   logic [9*N-1:0] req_addr;
   logic           write_start;
   logic           update_start;
   logic           busy;
   logic [7:0]     write_ascii_data;
   logic [8:0]     write_base_addr;

   always #5 clk = ~clk;

   oled_write_arbiter #(
      .N_REQ         (N),
      .UPDATE_PERIOD (P),
      .CNT_W         (8)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .en               (en),
      .req              (req),
      .req_ascii        (req_ascii),
      .req_addr         (req_addr),
      .force_update     (force_update),
      .gnt              (gnt),
      .done             (done),
      .write_start      (write_start),
      .write_ascii_data (write_ascii_data),
      .write_base_addr  (write_base_addr),
      .write_ready      (write_ready),
      .update_start     (update_start),
      .update_ready     (update_ready),
      .busy             (busy)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   // stimulus knobs
   logic [7:0] r_ascii [N];
   logic [8:0] r_addr  [N];
   int  cyc      = 0;
   int  req_mode = 0;   // 0 none, 1 random, 2 all held
   int  en_mode  = 0;   // 0 low, 1 high, 2 random toggling
   bit  force_on = 1'b0;
   bit  rst_cmd  = 1'b1;

   // OLED_ctrl device model
   int  w_phase = 0, w_hold = 0, w_low = 0;
   int  u_phase = 0, u_hold = 0, u_low = 0;
   bit  w_orphan = 1'b0, u_orphan = 1'b0;
   int  done_due = -1, upd_due = -1;

   // job-level reference model
   bit           m_busy = 1'b0, m_dirty = 1'b0, m_force = 1'b0, upd_seen = 1'b0;
   int           m_ptr = 0, last_upd = 0;
   logic [N-1:0] m_cur = '0;

   task automatic step();
      logic [N-1:0] exp_gnt;
      logic [N-1:0] exp_done;
      bit exp_wr, exp_upd, ok;
      int w;
      @(posedge clk);
      #1;
      cyc++;
      exp_gnt  = '0;
      exp_done = '0;
      exp_wr   = 1'b0;
      exp_upd  = 1'b0;
      w        = 0;
      if (rst) begin
         m_busy = 0; m_dirty = 0; m_force = 0; upd_seen = 0;
         m_ptr = 0; m_cur = '0; done_due = -1; upd_due = -1;
         w_orphan = (w_phase != 0);
         u_orphan = (u_phase != 0);
         check("rst_ascii", write_ascii_data, 0);
         check("rst_addr", write_base_addr, 0);
      end else begin
         if (done_due == cyc) exp_done = m_cur;
         ok = !upd_seen || (cyc - 1 - last_upd >= P);
         if (!m_busy && en && (m_dirty || m_force) && ok && update_ready) begin
            exp_upd = 1'b1;
         end else if (!m_busy && en && (req != '0) && write_ready) begin
            exp_wr = 1'b1;
            for (int k = 0; k < N; k++) begin
               w = (m_ptr + k) % N;
               if (req[w]) break;
            end
            exp_gnt[w] = 1'b1;
            check("ascii", write_ascii_data, r_ascii[w]);
            check("addr", write_base_addr, r_addr[w]);
            m_ptr = (w + 1) % N;
            m_cur = exp_gnt;
         end
         if (exp_upd) begin
            last_upd = cyc;
            upd_seen = 1'b1;
         end
         if (exp_wr || exp_upd) m_busy = 1'b1;
         if (done_due == cyc || upd_due == cyc) m_busy = 1'b0;
         m_dirty = (exp_done != '0) ? 1'b1 : (exp_upd ? 1'b0 : m_dirty);
         m_force = force_update ? 1'b1 : (exp_upd ? 1'b0 : m_force);
      end
      check("gnt", gnt, exp_gnt);
      check("done", done, exp_done);
      check("write_start", write_start, exp_wr);
      check("update_start", update_start, exp_upd);
      check("busy", busy, m_busy);

      // device reaction and ready waveforms
      if (exp_wr) begin
         w_phase = 1; w_hold = $urandom_range(0, 3); w_low = $urandom_range(0, 19);
      end
      if (exp_upd) begin
         u_phase = 1; u_hold = $urandom_range(0, 3); u_low = $urandom_range(0, 19);
      end
      if (w_phase == 1) begin
         if (w_hold > 0) begin write_ready = 1'b1; w_hold--; end
         else begin write_ready = 1'b0; w_phase = 2; end
      end else if (w_phase == 2) begin
         if (w_low > 0) begin write_ready = 1'b0; w_low--; end
         else begin
            write_ready = 1'b1; w_phase = 0;
            if (!w_orphan) done_due = cyc + 1;
            w_orphan = 1'b0;
         end
      end else begin
         write_ready = ($urandom_range(0, 7) != 0);
      end
      if (u_phase == 1) begin
         if (u_hold > 0) begin update_ready = 1'b1; u_hold--; end
         else begin update_ready = 1'b0; u_phase = 2; end
      end else if (u_phase == 2) begin
         if (u_low > 0) begin update_ready = 1'b0; u_low--; end
         else begin
            update_ready = 1'b1; u_phase = 0;
            if (!u_orphan) upd_due = cyc + 1;
            u_orphan = 1'b0;
         end
      end else begin
         update_ready = ($urandom_range(0, 7) != 0);
      end

      // requesters hold until granted, occasionally give up early
      for (int i = 0; i < N; i++) begin
         if (exp_gnt[i]) req[i] = 1'b0;
         if (req_mode == 0) begin
            req[i] = 1'b0;
         end else if (!req[i]) begin
            if (req_mode == 2 || $urandom_range(0, 3) == 0) begin
               req[i]     = 1'b1;
               r_ascii[i] = 8'($urandom);
               r_addr[i]  = 9'($urandom);
            end
         end else if (req_mode == 1 && $urandom_range(0, 31) == 0) begin
            req[i] = 1'b0;
         end
         req_ascii[i*8 +: 8] = r_ascii[i];
         req_addr[i*9 +: 9]  = r_addr[i];
      end

      case (en_mode)
         0:       en = 1'b0;
         1:       en = 1'b1;
         default: if ($urandom_range(0, 49) == 0) en = ~en;
      endcase
      force_update = force_on && ($urandom_range(0, 39) == 0);
      rst = rst_cmd;
   endtask

   initial begin
      int t;
      rst = 1'b1; en = 1'b0; force_update = 1'b0;
      write_ready = 1'b1; update_ready = 1'b1;
      req = '0; req_ascii = '0; req_addr = '0;
      for (int i = 0; i < N; i++) begin
         r_ascii[i] = '0;
         r_addr[i]  = '0;
      end

      repeat (3) step();
      rst_cmd = 1'b0;
      en_mode = 1; req_mode = 1; force_on = 1'b1;
      repeat (3000) step();
      en_mode = 2;
      repeat (1500) step();
      en_mode = 1; req_mode = 2; force_on = 1'b0;
      repeat (400) step();
      req_mode = 0;
      repeat (300) step();

      // reset while a write is in flight
      req_mode = 2;
      t = 0;
      while (t < 300 && !(m_busy && w_phase != 0)) begin
         step();
         t++;
      end
      check("reach_write", 32'(m_busy && w_phase != 0), 1);
      rst_cmd = 1'b1;
      step();
      rst_cmd = 1'b0;
      en_mode = 0;
      step();
      t = 0;
      while (t < 200 && (w_phase != 0 || u_phase != 0)) begin
         step();
         t++;
      end
      check("drain", 32'(w_phase == 0 && u_phase == 0), 1);
      en_mode = 1;
      t = 0;
      step();
      while (t < 100 && gnt == '0) begin
         step();
         t++;
      end
      check("post_rst_first_gnt", gnt, 4'b0001);
      repeat (200) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/oled_write_arbiter.md
Name: oled_write_arbiter

Overview:
- Shares the single character-write port and display-update port of OLED_ctrl among N independent requesters, e.g. per-channel sample formatters, a status line and a splash writer.
- Performs round-robin arbitration of single-character write jobs.
- Schedules rate-limited update_start commands whenever the local bitmap is dirty.
- Sits between the formatter blocks and OLED_ctrl, in place of a hand-sequenced write/update loop.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- UPDATE_PERIOD, 1_000_000, minimum clk cycles between consecutive update_start pulses (10 ms at 100 MHz); must be at least 2.
- CNT_W, 20, width of the update period counter; must satisfy 2**CNT_W > UPDATE_PERIOD.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  display initialised; when low, no new job or update is issued
- req  in  N_REQ  per-requester write request; held high with data stable until gnt
- req_ascii  in  8*N_REQ  flattened ASCII codes; requester i uses bits [8i+7:8i]
- req_addr  in  9*N_REQ  flattened write_base_addr values (row in [8:7], x pixel in [6:0])
- force_update  in  1  single-cycle pulse; sets a pending-update flag, which issues an update even if not dirty
- gnt  out  N_REQ  one-hot single-cycle pulse when requester i's job is issued
- done  out  N_REQ  one-hot single-cycle pulse when requester i's write has completed
- write_start  out  1  to OLED_ctrl
- write_ascii_data  out  8  to OLED_ctrl, registered
- write_base_addr  out  9  to OLED_ctrl, registered
- write_ready  in  1  from OLED_ctrl
- update_start  out  1  to OLED_ctrl
- update_ready  in  1  from OLED_ctrl
- busy  out  1  high in any state other than IDLE

Behaviour:

Reset:
- All outputs 0.
- state=IDLE, rr_ptr=0, dirty=0, force_pend=0.
- Period counter preloaded to UPDATE_PERIOD (expired), so the first update is not delayed.
- Reset mid-operation abandons the job: no done pulse, and the OLED_ctrl command runs to completion unobserved.

OLED handshake:
- Start is a 1-cycle pulse, issued only when the matching ready is high.
- After a start, the command is complete once ready has been seen low and then high again.
- A ready that stays high on the cycle after start does not count as completion.

Period counter:
- Saturating up-counter; cleared on update_start.
- upd_ok = (counter >= UPDATE_PERIOD).

State machine (one transition per cycle):
- IDLE:
  - If en, (dirty|force_pend), upd_ok and update_ready: update_start=1, go to U_LOW. Update has priority over writes.
  - Else if en, |req and write_ready: pick the winner (first set bit of req searching from rr_ptr upward, wrapping). Register its ascii/addr onto write_*, pulse write_start and gnt[winner], latch cur=winner, set rr_ptr=(winner+1) mod N_REQ, go to W_LOW.
- W_LOW: wait for write_ready==0, then go to W_HIGH.
- W_HIGH: on write_ready==1, pulse done[cur], set dirty=1, go to IDLE.
- U_LOW: clear dirty and force_pend on entry (on the cycle update_start is asserted); wait for update_ready==0, then go to U_HIGH.
- U_HIGH: on update_ready==1, go to IDLE.

Flag timing:
- A write completing during U_LOW/U_HIGH cannot happen (single outstanding command).
- force_update arriving in any state sets force_pend, except on the exact cycle it is cleared; in that case set wins.

Arbitration and timing rules:
- Latency: req rising in IDLE with write_ready=1 gives gnt and write_start in the same registered cycle, one clk after req is sampled.
- A req deasserted before gnt is simply dropped.
- gnt and done never pulse for the same requester in the same cycle.
- en low blocks new issues only; a command in flight completes normally.
- Throughput: back-to-back jobs are separated by at least one IDLE cycle.

Decomposition:
- Package oled_arb_pkg: state encoding localparams (IDLE, W_LOW, W_HIGH, U_LOW, U_HIGH), ADDR_W=9, CHAR_W=8.
- Sub-module rr_arbiter (req, ptr → one-hot grant, grant index), purely combinational, reused by future shared-SPI logic.

Test Plan:
- Single job: req=4'b0001, ascii=8'h41, addr=9'h008. Expect gnt[0] one cycle after req, write_ascii_data=8'h41, write_base_addr=9'h008, one-cycle write_start. With the model holding write_ready low for 20 cycles, done[0] comes exactly one cycle after write_ready returns high.
- Round-robin: req=4'b1111 held continuously. Expect grant order 0,1,2,3,0. With req=4'b1010 after granting 1, the next grant is 3, then 1.
- Update scheduling: UPDATE_PERIOD=50, 3 writes completed within 10 cycles. Expect exactly one update_start, with the next no sooner than 50 cycles later and only if dirty. No update when clean and no force_update.
- force_update pulse while idle and clean, counter expired: expect update_start within 2 cycles. Pulse during U_HIGH: expect a second update after the period.
- Handshake robustness: model keeps write_ready high 3 cycles after write_start. Expect no done until ready has gone low then high. en=0 with pending req: no gnt until en=1.
- rst asserted in W_LOW: expect all outputs 0 next cycle, no done, and rr_ptr=0 so requester 0 wins first afterward.
